// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT descriptor pipeline: histogram word layout
// and the descriptor builder state encoding.
package sift_pkg;

    localparam int HIST_BINS  = 8;
    localparam int BIN_BITS   = 3;
    localparam int HIST_WIDTH = HIST_BINS * BIN_BITS;
    localparam int SUBPATCHES = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SUB_START,
        SUB_WAIT,
        WRITE,
        FINISH
    } desc_state_t;

endpackage

// File: rtl/descriptor_builder.sv
// Descriptor builder: walks the keypoint BRAM, runs the neighbouring
// histogram engine once per 2x2 subpatch and writes the four concatenated
// histograms as one descriptor word per keypoint. Keypoints whose patch would
// cross the image border get an all-zero descriptor and are counted as skipped.
module descriptor_builder #(
    parameter int WIDTH         = 64,
    parameter int HEIGHT        = 64,
    parameter int MAX_KEYPOINTS = 64,
    parameter int PATCH_SIZE    = 4,
    parameter int HIST_WIDTH    = sift_pkg::HIST_WIDTH,
    parameter int BRAM_LATENCY  = 2,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int KA = $clog2(MAX_KEYPOINTS)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start,
    input  logic [KA:0]             num_keypoints,
    output logic [KA-1:0]           kp_read_addr,
    input  logic [XW+YW-1:0]        kp_data_in,
    output logic                    hist_start,
    output logic [XW-1:0]           hist_x,
    output logic [YW-1:0]           hist_y,
    input  logic [HIST_WIDTH-1:0]   hist_in,
    input  logic                    hist_done,
    output logic                    desc_wea,
    output logic [KA-1:0]           desc_addr,
    output logic [4*HIST_WIDTH-1:0] desc_data,
    output logic [KA:0]             skipped_count,
    output logic                    busy,
    output logic                    done
);

    import sift_pkg::*;

    localparam int HALF = PATCH_SIZE / 2;
    // Wide enough to hold BRAM_LATENCY even when it is 0 or a power of two
    localparam int LW   = $clog2(BRAM_LATENCY + 2);

    desc_state_t             state_reg;
    logic [KA:0]             count_reg;
    logic [KA:0]             idx_reg;
    logic [XW-1:0]           kx_reg;
    logic [YW-1:0]           ky_reg;
    logic                    kp_valid_reg;
    logic [1:0]              sub_reg;
    logic [LW-1:0]           wait_reg;
    logic [4*HIST_WIDTH-1:0] acc_reg;

    logic [KA:0]             count_clamped;
    logic [KA:0]             idx_next;
    logic [XW:0]             kx_far;
    logic [YW:0]             ky_far;
    logic                    kp_outside;
    logic [XW:0]             sub_x_wide;
    logic [YW:0]             sub_y_wide;
    logic [4*HIST_WIDTH-1:0] acc_merged;

    // Requests beyond the BRAM depth are limited to the BRAM depth
    assign count_clamped = (num_keypoints > (KA+1)'(MAX_KEYPOINTS))
                         ? (KA+1)'(MAX_KEYPOINTS) : num_keypoints;
    assign idx_next      = idx_reg + (KA+1)'(1);

    // Border test is one bit wider than the coordinates so 63+4 cannot wrap
    assign kx_far     = {1'b0, kx_reg} + (XW+1)'(PATCH_SIZE);
    assign ky_far     = {1'b0, ky_reg} + (YW+1)'(PATCH_SIZE);
    assign kp_outside = (kx_far > (XW+1)'(WIDTH)) || (ky_far > (YW+1)'(HEIGHT));

    // Subpatch origin: bit 0 of sub selects the right column, bit 1 the bottom row
    assign sub_x_wide = {1'b0, kx_reg} + (sub_reg[0] ? (XW+1)'(HALF) : '0);
    assign sub_y_wide = {1'b0, ky_reg} + (sub_reg[1] ? (YW+1)'(HALF) : '0);

    // Accumulator with the incoming histogram dropped into slice sub
    generate
        for (genvar gi = 0; gi < SUBPATCHES; gi++) begin : g_slice
            assign acc_merged[gi*HIST_WIDTH +: HIST_WIDTH] =
                (sub_reg == 2'(gi)) ? hist_in : acc_reg[gi*HIST_WIDTH +: HIST_WIDTH];
        end
    endgenerate

    // Pass sequencer: fetch keypoint, four histogram calls, one descriptor write
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            idx_reg       <= '0;
            kx_reg        <= '0;
            ky_reg        <= '0;
            kp_valid_reg  <= 1'b0;
            sub_reg       <= '0;
            wait_reg      <= '0;
            acc_reg       <= '0;
            kp_read_addr  <= '0;
            hist_start    <= 1'b0;
            hist_x        <= '0;
            hist_y        <= '0;
            desc_wea      <= 1'b0;
            desc_addr     <= '0;
            desc_data     <= '0;
            skipped_count <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            hist_start <= 1'b0;
            desc_wea   <= 1'b0;
            done       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        count_reg     <= count_clamped;
                        idx_reg       <= '0;
                        skipped_count <= '0;
                        acc_reg       <= '0;
                        kp_valid_reg  <= 1'b0;
                        busy          <= 1'b1;
                        kp_read_addr  <= '0;
                        wait_reg      <= LW'(BRAM_LATENCY);
                        state_reg     <= (count_clamped == '0) ? FINISH : FETCH;
                    end
                end
                FETCH: begin
                    // Count out the BRAM latency, latch the coordinates, then decide
                    if (wait_reg != '0) begin
                        wait_reg <= wait_reg - LW'(1);
                    end else if (!kp_valid_reg) begin
                        kx_reg       <= kp_data_in[XW+YW-1 -: XW];
                        ky_reg       <= kp_data_in[YW-1:0];
                        kp_valid_reg <= 1'b1;
                    end else begin
                        kp_valid_reg <= 1'b0;
                        if (kp_outside) begin
                            acc_reg       <= '0;
                            skipped_count <= skipped_count + (KA+1)'(1);
                            state_reg     <= WRITE;
                        end else begin
                            sub_reg   <= '0;
                            state_reg <= SUB_START;
                        end
                    end
                end
                SUB_START: begin
                    hist_x     <= sub_x_wide[XW-1:0];
                    hist_y     <= sub_y_wide[YW-1:0];
                    hist_start <= 1'b1;
                    state_reg  <= SUB_WAIT;
                end
                SUB_WAIT: begin
                    if (hist_done) begin
                        acc_reg <= acc_merged;
                        if (sub_reg == 2'd3) begin
                            state_reg <= WRITE;
                        end else begin
                            sub_reg   <= sub_reg + 2'd1;
                            state_reg <= SUB_START;
                        end
                    end
                end
                WRITE: begin
                    desc_wea  <= 1'b1;
                    desc_addr <= idx_reg[KA-1:0];
                    desc_data <= acc_reg;
                    idx_reg   <= idx_next;
                    if (idx_next == count_reg) begin
                        state_reg <= FINISH;
                    end else begin
                        kp_read_addr <= idx_next[KA-1:0];
                        wait_reg     <= LW'(BRAM_LATENCY);
                        state_reg    <= FETCH;
                    end
                end
                FINISH: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_descriptor_builder.sv
// Bench for descriptor_builder with a 2-cycle keypoint BRAM model and a
// histogram engine model of random latency.
module tb_descriptor_builder;

    localparam int MAXK = 64;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start;
    logic [6:0]  num_keypoints;
    logic [5:0]  kp_read_addr;
    logic [11:0] kp_data_in;
    logic        hist_start;
    logic [5:0]  hist_x;
    logic [5:0]  hist_y;
    logic [23:0] hist_in;
    logic        hist_done;
    logic        desc_wea;
    logic [5:0]  desc_addr;
    logic [95:0] desc_data;
    logic [6:0]  skipped_count;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    descriptor_builder dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .num_keypoints(num_keypoints),
        .kp_read_addr(kp_read_addr), .kp_data_in(kp_data_in),
        .hist_start(hist_start), .hist_x(hist_x), .hist_y(hist_y),
        .hist_in(hist_in), .hist_done(hist_done),
        .desc_wea(desc_wea), .desc_addr(desc_addr), .desc_data(desc_data),
        .skipped_count(skipped_count), .busy(busy), .done(done)
    );

    // Keypoint BRAM: two register stages of read latency
    logic [11:0] kp_mem [0:MAXK-1];
    logic [11:0] bram_s1, bram_s2;
    always @(posedge clk_in) begin
        bram_s1 <= kp_mem[kp_read_addr];
        bram_s2 <= bram_s1;
    end
    assign kp_data_in = bram_s2;

    // Histogram engine model and output monitor
    int          hist_mode = 1;   // 0: call number within pass, 1: function of (x,y)
    int          call_base = 0;
    int          calls_total = 0;
    bit          hm_busy = 0;
    int          hm_cnt = 0;
    logic        hm_done = 1'b0;
    logic [23:0] hm_data = '0;
    logic        inj_done = 1'b0;
    int          hs_long = 0;
    logic        prev_hs = 1'b0;
    logic [5:0]  call_x_q[$];
    logic [5:0]  call_y_q[$];
    logic [5:0]  wr_addr_q[$];
    logic [95:0] wr_data_q[$];
    int          wr_calls_q[$];

    function automatic logic [23:0] hval(input logic [5:0] x, input logic [5:0] y);
        logic [11:0] a;
        a = {x, y};
        return {a ^ 12'h5A3, a};
    endfunction

    assign hist_done = hm_done | inj_done;
    assign hist_in   = hm_done ? hm_data : 24'hABCDEF;

    always @(negedge clk_in) begin
        if (desc_wea) begin
            wr_addr_q.push_back(desc_addr);
            wr_data_q.push_back(desc_data);
            wr_calls_q.push_back(calls_total);
        end
        if (hist_start && prev_hs) hs_long <= hs_long + 1;
        prev_hs <= hist_start;
        if (rst_in) begin
            hm_busy <= 0;
            hm_done <= 1'b0;
        end else begin
            hm_done <= 1'b0;
            if (hm_busy) begin
                if (hm_cnt <= 1) begin
                    hm_done <= 1'b1;
                    hm_busy <= 0;
                end else begin
                    hm_cnt <= hm_cnt - 1;
                end
            end
            if (hist_start) begin
                call_x_q.push_back(hist_x);
                call_y_q.push_back(hist_y);
                hm_data     <= (hist_mode == 0) ? 24'(calls_total - call_base + 1) : hval(hist_x, hist_y);
                calls_total <= calls_total + 1;
                hm_busy     <= 1;
                hm_cnt      <= $urandom_range(1, 4);
            end
        end
    end

    // Reference model: expected descriptor writes for a pass over kp_mem
    int          exp_addr_q[$];
    logic [95:0] exp_data_q[$];
    int          exp_skip;

    task automatic build_expected(input int cnt);
        int n;
        n = (cnt > MAXK) ? MAXK : cnt;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_skip = 0;
        for (int k = 0; k < n; k++) begin
            int x, y;
            x = int'(kp_mem[k][11:6]);
            y = int'(kp_mem[k][5:0]);
            if (x + 4 > 64 || y + 4 > 64) begin
                exp_skip++;
                exp_data_q.push_back(96'h0);
            end else begin
                exp_data_q.push_back({hval(6'(x+2), 6'(y+2)), hval(6'(x), 6'(y+2)),
                                      hval(6'(x+2), 6'(y)),   hval(6'(x), 6'(y))});
            end
            exp_addr_q.push_back(k);
        end
    endtask

    function automatic logic [11:0] rand_kp();
        logic [5:0] x, y;
        x = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(58, 63)) : 6'($urandom_range(0, 63));
        y = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(58, 63)) : 6'($urandom_range(0, 63));
        return {x, y};
    endfunction

    // Start one pass and wait (bounded) for done; optional disturbance in FETCH
    task automatic run_pass(input int cnt, input bit disturb,
                            output int lat, output bit busy_first, output bit busy_at_done);
        bit ok;
        ok = 0;
        lat = 0;
        busy_first = 0;
        busy_at_done = 1;
        num_keypoints = 7'(cnt);
        start = 1'b1;
        while (lat < 20000) begin
            @(negedge clk_in);
            lat++;
            start    = (disturb && lat == 3);
            inj_done = (disturb && lat == 2);
            if (disturb && lat == 3) num_keypoints = 7'd1;
            if (lat == 1) busy_first = busy;
            if (done) begin
                ok = 1;
                busy_at_done = busy;
                break;
            end
        end
        start = 1'b0;
        inj_done = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pass_timeout: no done after %0d cycles, required done", lat);
        end
        $display("pass count=%0d cycles=%0d skipped=%0d", cnt, lat, skipped_count);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        start = 1'b0;
        num_keypoints = '0;
        repeat (3) @(negedge clk_in);
        checks++; if ({busy, done, desc_wea, hist_start} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b required 0000", {busy, done, desc_wea, hist_start}); end
        checks++; if ({kp_read_addr, hist_x, hist_y, desc_addr} !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", {kp_read_addr, hist_x, hist_y, desc_addr}); end
        checks++; if (desc_data !== 96'h0) begin errors++; $display("FAIL reset_data: got %h required 0", desc_data); end
        checks++; if (skipped_count !== 7'd0) begin errors++; $display("FAIL reset_skipped: got %0d required 0", skipped_count); end
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_single();
        int lat, wbase, cbase;
        bit bf, bd;
        logic [5:0] ex[4] = '{6'd10, 6'd12, 6'd10, 6'd12};
        logic [5:0] ey[4] = '{6'd20, 6'd20, 6'd22, 6'd22};
        kp_mem[0] = {6'd10, 6'd20};
        hist_mode = 0;
        call_base = calls_total;
        wbase = wr_addr_q.size();
        cbase = call_x_q.size();
        run_pass(1, 0, lat, bf, bd);
        checks++; if (call_x_q.size() - cbase !== 4) begin errors++; $display("FAIL single_calls: got %0d required 4", call_x_q.size() - cbase); end
        for (int k = 0; k < 4 && cbase + k < call_x_q.size(); k++) begin
            checks++;
            if (call_x_q[cbase+k] !== ex[k] || call_y_q[cbase+k] !== ey[k]) begin
                errors++;
                $display("FAIL single_coord%0d: got (%0d,%0d) required (%0d,%0d)", k, call_x_q[cbase+k], call_y_q[cbase+k], ex[k], ey[k]);
            end
        end
        checks++; if (wr_addr_q.size() - wbase !== 1) begin errors++; $display("FAIL single_writes: got %0d required 1", wr_addr_q.size() - wbase); end
        if (wr_addr_q.size() > wbase) begin
            checks++; if (wr_addr_q[wbase] !== 6'd0) begin errors++; $display("FAIL single_addr: got %0d required 0", wr_addr_q[wbase]); end
            checks++; if (wr_data_q[wbase] !== 96'h000004_000003_000002_000001) begin errors++; $display("FAIL single_data: got %h required 000004000003000002000001", wr_data_q[wbase]); end
        end
        hist_mode = 1;
    endtask

    task automatic test_border();
        int lat, wbase, cbase;
        bit bf, bd;
        kp_mem[0] = {6'd61, 6'd5};
        kp_mem[1] = {6'd5, 6'd5};
        build_expected(2);
        wbase = wr_addr_q.size();
        cbase = calls_total;
        run_pass(2, 0, lat, bf, bd);
        checks++; if (wr_addr_q.size() - wbase !== 2) begin errors++; $display("FAIL border_writes: got %0d required 2", wr_addr_q.size() - wbase); end
        for (int k = 0; k < 2 && wbase + k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[wbase+k] !== 6'(exp_addr_q[k]) || wr_data_q[wbase+k] !== exp_data_q[k]) begin
                errors++;
                $display("FAIL border_w%0d: got %0d/%h required %0d/%h", k, wr_addr_q[wbase+k], wr_data_q[wbase+k], exp_addr_q[k], exp_data_q[k]);
            end
        end
        if (wr_calls_q.size() > wbase) begin
            checks++; if (wr_calls_q[wbase] - cbase !== 0) begin errors++; $display("FAIL border_precalls: got %0d required 0", wr_calls_q[wbase] - cbase); end
        end
        checks++; if (calls_total - cbase !== 4) begin errors++; $display("FAIL border_calls: got %0d required 4", calls_total - cbase); end
        checks++; if (skipped_count !== 7'(exp_skip)) begin errors++; $display("FAIL border_skipped: got %0d required %0d", skipped_count, exp_skip); end
    endtask

    task automatic test_zero();
        int lat, wbase;
        bit bf, bd;
        wbase = wr_addr_q.size();
        run_pass(0, 0, lat, bf, bd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d required 2", lat); end
        checks++; if (bf !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b required 1", bf); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL zero_busy_done: got %b required 0", bd); end
        checks++; if (wr_addr_q.size() !== wbase) begin errors++; $display("FAIL zero_writes: got %0d required 0", wr_addr_q.size() - wbase); end
        checks++; if (skipped_count !== 7'd0) begin errors++; $display("FAIL zero_skipped: got %0d required 0", skipped_count); end
    endtask

    // Shared by the disturbed and random scenarios: compare one pass against the model
    task automatic test_pass_random(input int cnt, input bit disturb, input bit fill);
        int lat, wbase;
        bit bf, bd;
        if (fill) for (int k = 0; k < MAXK; k++) kp_mem[k] = rand_kp();
        build_expected(cnt);
        wbase = wr_addr_q.size();
        run_pass(cnt, disturb, lat, bf, bd);
        checks++; if (wr_addr_q.size() - wbase !== exp_addr_q.size()) begin errors++; $display("FAIL pass%0d_writes: got %0d required %0d", cnt, wr_addr_q.size() - wbase, exp_addr_q.size()); end
        for (int k = 0; k < exp_addr_q.size() && wbase + k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[wbase+k] !== 6'(exp_addr_q[k]) || wr_data_q[wbase+k] !== exp_data_q[k]) begin
                errors++;
                $display("FAIL pass%0d_w%0d: got %0d/%h required %0d/%h", cnt, k, wr_addr_q[wbase+k], wr_data_q[wbase+k], exp_addr_q[k], exp_data_q[k]);
            end
        end
        checks++; if (skipped_count !== 7'(exp_skip)) begin errors++; $display("FAIL pass%0d_skipped: got %0d required %0d", cnt, skipped_count, exp_skip); end
    endtask

    task automatic test_ignored();
        for (int k = 0; k < 3; k++) kp_mem[k] = {6'($urandom_range(0, 59)), 6'($urandom_range(0, 59))};
        test_pass_random(3, 1, 0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 4; p++) test_pass_random($urandom_range(1, 12), 0, 1);
        checks++; if (hs_long !== 0) begin errors++; $display("FAIL hist_start_width: got %0d long pulses required 0", hs_long); end
    endtask

    task automatic test_reset_mid();
        int cbase, wbase, n, extra_done;
        kp_mem[0] = {6'd3, 6'd7};
        kp_mem[1] = {6'd20, 6'd30};
        kp_mem[2] = {6'd40, 6'd11};
        cbase = calls_total;
        wbase = wr_addr_q.size();
        num_keypoints = 7'd3;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        n = 0;
        while (calls_total - cbase < 5 && n < 2000) begin @(negedge clk_in); n++; end
        checks++; if (calls_total - cbase < 5) begin errors++; $display("FAIL mid_reach: got %0d calls required 5", calls_total - cbase); end
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++; if ({busy, done, desc_wea, hist_start} !== 4'b0) begin errors++; $display("FAIL mid_ctrl: got %b required 0000", {busy, done, desc_wea, hist_start}); end
        checks++; if ({kp_read_addr, hist_x, hist_y, desc_addr} !== 24'h0) begin errors++; $display("FAIL mid_addr: got %h required 0", {kp_read_addr, hist_x, hist_y, desc_addr}); end
        checks++; if (desc_data !== 96'h0) begin errors++; $display("FAIL mid_data: got %h required 0", desc_data); end
        rst_in = 1'b0;
        extra_done = 0;
        repeat (60) begin @(negedge clk_in); if (done) extra_done++; end
        checks++; if (extra_done !== 0) begin errors++; $display("FAIL mid_done: got %0d pulses required 0", extra_done); end
        checks++; if (wr_addr_q.size() - wbase !== 1) begin errors++; $display("FAIL mid_writes: got %0d required 1", wr_addr_q.size() - wbase); end
        test_pass_random(3, 0, 0);
    endtask

    task automatic test_clamp();
        test_pass_random(MAXK + 5, 0, 1);
    endtask

    initial begin
        inj_done = 1'b0;
        for (int k = 0; k < MAXK; k++) kp_mem[k] = '0;
        test_reset();
        test_single();
        test_border();
        test_zero();
        test_ignored();
        test_random();
        test_reset_mid();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
